// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [REG_W-1:0]  val;
  } rf_wr_t;

  // Decoded destination; r0 is hard-wired so it never marks a hazard.
  function automatic logic [NUM_REGS-1:0] onehot_dest(input logic [ADDR_W-1:0] dest);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (dest != '0) oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of register writes; exposes every slot with a valid
// bit so the owner can build a pending-destination mask.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  rf_wr_t               push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output rf_wr_t               head,
  output rf_wr_t [DEPTH-1:0]   entries,
  output logic   [DEPTH-1:0]   entry_vld
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic   [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic   [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  rf_wr_t [DEPTH-1:0] mem_q, mem_d;
  logic   [PTR_W-1:0] count_c;
  logic   [IDX_W-1:0] off_c;
  logic               do_push_c;
  logic               do_pop_c;

  // Extra pointer bit distinguishes full from empty.
  assign count_c   = wr_ptr_q - rd_ptr_q;
  assign full      = (count_c == PTR_W'(DEPTH));
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign head      = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign entries   = mem_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push_c) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // A slot is live when its distance from the read index is below occupancy.
  always_comb begin
    entry_vld = '0;
    off_c     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off_c        = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
      entry_vld[i] = ({1'b0, off_c} < count_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (primary) and a
// buffered multi-cycle source (secondary). Define RF_ARB_STARVE_GUARD_EN to
// build the starvation counter that forces the FIFO head through.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [ADDR_W-1:0]   wb_dest,
  input  logic [REG_W-1:0]    wb_val,
  input  logic                mc_valid,
  output logic                mc_ready,
  input  logic [ADDR_W-1:0]   mc_dest,
  input  logic [REG_W-1:0]    mc_val,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_dest,
  output logic [REG_W-1:0]    rf_wval,
  output logic [NUM_REGS-1:0] pend_mask
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rf_write_arbiter: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("rf_write_arbiter: STARVE_MAX must be >= 1");
  end

  logic                    fifo_full;
  logic                    fifo_empty;
  rf_wr_t                  fifo_head;
  rf_wr_t [FIFO_DEPTH-1:0] fifo_entries;
  logic   [FIFO_DEPTH-1:0] fifo_vld;
  rf_wr_t                  push_data_c;
  logic                    push_c;
  logic                    prim_win_c;
  logic                    head_win_c;
  logic                    force_head_c;

  logic                rf_we_q,   rf_we_d;
  logic [ADDR_W-1:0]   rf_dest_q, rf_dest_d;
  logic [REG_W-1:0]    rf_wval_q, rf_wval_d;
  logic                out_sec_q, out_sec_d;

  assign mc_ready         = !fifo_full && !rst;
  assign push_c           = mc_valid && mc_ready;
  assign push_data_c.dest = mc_dest;
  assign push_data_c.val  = mc_val;

  rf_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (head_win_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .entries   (fifo_entries),
    .entry_vld (fifo_vld)
  );

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Counts consecutive cycles a queued head lost to the primary.
  assign force_head_c = (starve_cnt_q == CNT_W'(STARVE_MAX));
  assign wb_ready     = !force_head_c;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || head_win_c) starve_cnt_d = '0;
    else                          starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_head_c = 1'b0;
  assign wb_ready     = 1'b1;
`endif

  assign prim_win_c = wb_valid && !force_head_c;
  assign head_win_c = !prim_win_c && !fifo_empty;

  // Output stage: register the winner; r0 writes are consumed but suppressed.
  always_comb begin
    rf_we_d   = 1'b0;
    out_sec_d = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_wval_d = rf_wval_q;
    if (prim_win_c) begin
      rf_we_d   = (wb_dest != '0);
      rf_dest_d = wb_dest;
      rf_wval_d = wb_val;
    end else if (head_win_c) begin
      rf_we_d   = (fifo_head.dest != '0);
      out_sec_d = (fifo_head.dest != '0);
      rf_dest_d = fifo_head.dest;
      rf_wval_d = fifo_head.val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_dest_q <= '0;
      rf_wval_q <= '0;
      out_sec_q <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_dest_q <= rf_dest_d;
      rf_wval_q <= rf_wval_d;
      out_sec_q <= out_sec_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dest = rf_dest_q;
  assign rf_wval = rf_wval_q;

  // Destinations still owed a secondary write: queued entries plus output stage.
  always_comb begin
    pend_mask = out_sec_q ? onehot_dest(rf_dest_q) : '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i]) pend_mask = pend_mask | onehot_dest(fifo_entries[i].dest);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_val = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_dest = '0;
  logic [31:0] mc_val = '0;
  logic        rf_we;
  logic [4:0]  rf_dest;
  logic [31:0] rf_wval;
  logic [31:0] pend_mask;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_val(wb_val),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_dest(mc_dest), .mc_val(mc_val),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_wval(rf_wval), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wb_valid = 1'b0; mc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wb_valid = 1'b0; mc_valid = 1'b0;
    #1;
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL rst_mc_ready: got %0b exp 0", mc_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", rf_we); end
    checks++; if (rf_dest !== 5'd0) begin errors++; $display("FAIL rst_dest: got %0d exp 0", rf_dest); end
    checks++; if (rf_wval !== 32'd0) begin errors++; $display("FAIL rst_wval: got %h exp 0", rf_wval); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL rst_pend: got %h exp 0", pend_mask); end
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL rst_after_mc_ready: got %0b exp 1", mc_ready); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rst_wb_ready: got %0b exp 1", wb_ready); end
  endtask

  task automatic test_primary();
    do_reset();
    @(negedge clk);
    wb_valid = 1'b1; wb_dest = 5'd3; wb_val = 32'hDEADBEEF;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL prim_ready: got %0b exp 1", wb_ready); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL prim_pend0: got %h exp 0", pend_mask); end
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL prim_we: got %0b exp 1", rf_we); end
    checks++; if (rf_dest !== 5'd3) begin errors++; $display("FAIL prim_dest: got %0d exp 3", rf_dest); end
    checks++; if (rf_wval !== 32'hDEADBEEF) begin errors++; $display("FAIL prim_wval: got %h exp deadbeef", rf_wval); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL prim_pend1: got %h exp 0", pend_mask); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL prim_we_idle: got %0b exp 0", rf_we); end
  endtask

  task automatic test_secondary();
    do_reset();
    @(negedge clk);
    mc_valid = 1'b1; mc_dest = 5'd7; mc_val = 32'h55;
    #1;
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL sec_ready: got %0b exp 1", mc_ready); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL sec_pend_n: got %h exp 0", pend_mask); end
    @(negedge clk);
    mc_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL sec_pend_n1: got %h exp 80", pend_mask); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sec_we_n1: got %0b exp 0", rf_we); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL sec_we_n2: got %0b exp 1", rf_we); end
    checks++; if (rf_dest !== 5'd7) begin errors++; $display("FAIL sec_dest: got %0d exp 7", rf_dest); end
    checks++; if (rf_wval !== 32'h55) begin errors++; $display("FAIL sec_wval: got %h exp 55", rf_wval); end
    checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL sec_pend_n2: got %h exp 80", pend_mask); end
    @(negedge clk);
    #1;
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL sec_pend_n3: got %h exp 0", pend_mask); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sec_we_n3: got %0b exp 0", rf_we); end
  endtask

  // FIFO filled while the primary streams; the head is held back until the
  // starvation guard fires (guard build) or the primary goes idle.
  task automatic test_fill_starve();
    logic       exp_mcr, exp_wbr;
    logic [4:0] exp_d;
    int         last;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      wb_valid = (c < 8); wb_dest = 5'd2; wb_val = 32'(c);
      mc_valid = (c < 2); mc_dest = (c == 0) ? 5'd9 : 5'd10; mc_val = 32'(100 + c);
      #1;
`ifdef RF_ARB_STARVE_GUARD_EN
      exp_mcr = (c < 2) || (c >= 6);
      exp_wbr = (c != 5);
      exp_d   = (c == 6) ? 5'd9 : (c == 9) ? 5'd10 : 5'd2;
      last    = 9;
`else
      exp_mcr = (c < 2) || (c >= 9);
      exp_wbr = 1'b1;
      exp_d   = (c == 9) ? 5'd9 : (c == 10) ? 5'd10 : 5'd2;
      last    = 10;
`endif
      checks++; if (mc_ready !== exp_mcr) begin errors++; $display("FAIL fill_mc_ready c%0d: got %0b exp %0b", c, mc_ready, exp_mcr); end
      checks++; if (wb_ready !== exp_wbr) begin errors++; $display("FAIL fill_wb_ready c%0d: got %0b exp %0b", c, wb_ready, exp_wbr); end
      if (c >= 1 && c <= last) begin
        checks++; if (rf_we !== 1'b1 || rf_dest !== exp_d) begin
          errors++; $display("FAIL fill_write c%0d: got we=%0b dest=%0d exp we=1 dest=%0d", c, rf_we, rf_dest, exp_d);
        end
      end
    end
    mc_valid = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic test_dest_zero();
    do_reset();
    @(negedge clk);
    mc_valid = 1'b1; mc_dest = 5'd0; mc_val = 32'h1234;
    #1;
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL z_ready: got %0b exp 1", mc_ready); end
    @(negedge clk);
    mc_dest = 5'd5; mc_val = 32'h77;
    #1;
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL z_pend_n1: got %h exp 0", pend_mask); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL z_we_n1: got %0b exp 0", rf_we); end
    @(negedge clk);
    mc_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL z_we_n2: got %0b exp 0", rf_we); end
    checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL z_pend_n2: got %h exp 20", pend_mask); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b1 || rf_dest !== 5'd5 || rf_wval !== 32'h77) begin
      errors++; $display("FAIL z_follow: got we=%0b dest=%0d val=%h exp we=1 dest=5 val=77", rf_we, rf_dest, rf_wval);
    end
    @(negedge clk);
    #1;
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL z_pend_n4: got %h exp 0", pend_mask); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    wb_valid = 1'b1; wb_dest = 5'd1; wb_val = 32'h1;
    mc_valid = 1'b1; mc_dest = 5'd4; mc_val = 32'h44;
    @(negedge clk);
    mc_dest = 5'd6; mc_val = 32'h66;
    @(negedge clk);
    mc_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h50) begin errors++; $display("FAIL rm_pend_pre: got %h exp 50", pend_mask); end
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL rm_full: got %0b exp 0", mc_ready); end
    rst = 1'b1; wb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL rm_pend_post: got %h exp 0", pend_mask); end
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL rm_mc_ready: got %0b exp 1", mc_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rm_no_write c%0d: got %0b exp 0", c, rf_we); end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    rf_wr_t      q[$];
    rf_wr_t      e;
    logic        exp_we, exp_sec, exp_wbr, prim, head, had;
    logic [4:0]  exp_dest;
    logic [31:0] exp_val, exp_pend;
    int          losses;
    do_reset();
    exp_we = 1'b0; exp_sec = 1'b0; exp_dest = '0; exp_val = '0; losses = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 149) == 0);
      wb_valid = ($urandom_range(0, 99) < (((cyc / 100) % 2 == 1) ? 90 : 35));
      wb_dest  = 5'($urandom_range(0, 31));
      wb_val   = $urandom;
      mc_valid = ($urandom_range(0, 99) < 55);
      mc_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      mc_val   = $urandom;
      #1;
`ifdef RF_ARB_STARVE_GUARD_EN
      exp_wbr = (losses != SMAX);
`else
      exp_wbr = 1'b1;
`endif
      exp_pend = '0;
      foreach (q[i]) if (q[i].dest != 5'd0) exp_pend[q[i].dest] = 1'b1;
      if (exp_sec) exp_pend[exp_dest] = 1'b1;
      if (rst) begin
        checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL rnd_rst_mc_ready cyc%0d: got %0b exp 0", cyc, mc_ready); end
      end else begin
        checks++; if (mc_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_mc_ready cyc%0d: got %0b exp %0b", cyc, mc_ready, q.size() < DEPTH); end
        checks++; if (wb_ready !== exp_wbr) begin errors++; $display("FAIL rnd_wb_ready cyc%0d: got %0b exp %0b", cyc, wb_ready, exp_wbr); end
        checks++; if (pend_mask !== exp_pend) begin errors++; $display("FAIL rnd_pend cyc%0d: got %h exp %h", cyc, pend_mask, exp_pend); end
        checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL rnd_we cyc%0d: got %0b exp %0b", cyc, rf_we, exp_we); end
        if (exp_we) begin
          checks++; if (rf_dest !== exp_dest || rf_wval !== exp_val) begin
            errors++; $display("FAIL rnd_data cyc%0d: got %0d/%h exp %0d/%h", cyc, rf_dest, rf_wval, exp_dest, exp_val);
          end
        end
      end
      if (rst) begin
        q.delete();
        exp_we = 1'b0; exp_sec = 1'b0; exp_dest = '0; exp_val = '0; losses = 0;
      end else begin
        had  = (q.size() > 0);
        prim = wb_valid && exp_wbr;
        head = !prim && had;
        if (prim) begin
          exp_we = (wb_dest != 5'd0); exp_sec = 1'b0; exp_dest = wb_dest; exp_val = wb_val;
        end else if (head) begin
          e = q.pop_front();
          exp_we = (e.dest != 5'd0); exp_sec = exp_we; exp_dest = e.dest; exp_val = e.val;
        end else begin
          exp_we = 1'b0; exp_sec = 1'b0;
        end
        losses = (had && !head) ? losses + 1 : 0;
        if (mc_valid && mc_ready) begin
          e.dest = mc_dest; e.val = mc_val;
          q.push_back(e);
        end
      end
    end
    rst = 1'b0; wb_valid = 1'b0; mc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_primary();
    test_secondary();
    test_fill_starve();
    test_dest_zero();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
